reg_wb_ctrl: RTL and testbench
==============================

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter ADDR_W, 5, register address width (32 registers).
REQ-003 Parameter DEPTH, 2, per-source queue depth in entries (power of two, at least 2).
REQ-004 The block SHALL use one clock, i_clk; reset is synchronous and active-high, i_rst, sampled on the i_clk rising edge.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_a_valid  in  1  ALU writeback request valid.
REQ-008 i_a_addr  in  ADDR_W  ALU destination register.
REQ-009 i_a_data  in  DATA_W  ALU result.
REQ-010 o_a_ready  out  1  ALU queue can accept.
REQ-011 i_l_valid, i_l_addr, i_l_data, o_l_ready  same widths and directions  load-unit writeback channel.
REQ-012 i_raddr1, i_raddr2  in  ADDR_W  decode-stage source registers for hazard check.
REQ-013 o_busy1, o_busy2  out  1  a write to i_raddr1 or i_raddr2 is pending.
REQ-014 o_we, o_waddr, o_wdata  out  1/ADDR_W/DATA_W  register-file write port, registered.
REQ-015 o_wr_count  out  16  number of register-file writes issued.

Function
REQ-016 A transfer on a channel SHALL occur at a rising edge where valid and ready are both high.
REQ-017 o_x_ready SHALL be high iff that channel's queue holds fewer than DEPTH entries; it SHALL NOT depend on a same-cycle pop.
REQ-018 A transfer with addr 0 SHALL be accepted and discarded: nothing is enqueued and o_we is never asserted for it.
REQ-019 Each channel queue SHALL be FIFO; ordering between the two channels is not guaranteed.
REQ-020 Each cycle, at most one entry SHALL be popped: the only non-empty queue, or the round-robin winner when both are non-empty.
REQ-021 Round-robin: the winner is the channel not granted at the most recent grant; the pointer updates on every grant; after reset ALU wins the first contest.
REQ-022 At the edge of a pop, o_we SHALL become 1 with the entry's addr and data; with no pop, o_we SHALL become 0 and o_waddr and o_wdata SHALL hold their values.
REQ-023 Latency: an entry accepted at edge t into an empty, uncontested queue SHALL drive o_we after edge t+1.
REQ-024 o_busyN SHALL be combinational: 1 iff i_raddrN is nonzero and equals the addr of any queued entry or of the current o_waddr while o_we=1.
REQ-025 o_wr_count SHALL increment at each edge that sets o_we=1 and wrap from 65535 to 0.
REQ-026 Both channels may transfer in the same cycle as a pop; full-queue back-pressure SHALL never drop or duplicate an entry.

Reset
REQ-027 While i_rst=1 at an edge: queues empty, o_we=0, o_waddr=0, o_wdata=0, o_wr_count=0, and the round-robin pointer favours ALU.
REQ-028 Reset mid-operation SHALL discard all queued entries without issuing writes; transfers presented during reset SHALL be ignored.
REQ-029 After reset, o_a_ready=1, o_l_ready=1 and o_busy1=o_busy2=0.

Structure
REQ-030 A shared package SHALL hold DATA_W, ADDR_W, DEPTH defaults and the counter width 16.
REQ-031 The per-channel queue SHALL be one sub-module, wb_fifo (push, pop, full, empty, head, per-entry addr visibility for the hazard check), instantiated twice.
REQ-032 The arbiter, output register and counter SHALL reside in reg_wb_ctrl.

Verification
REQ-033 ALU writes r5=0x0000_00AA at edge 1, load idle -> after edge 2, o_we=1, o_waddr=5, o_wdata=0xAA; o_wr_count=1.
REQ-034 Both channels valid every cycle (ALU r1..r4, load r11..r14) -> writes alternate A,L,A,L starting with A; ready drops when a queue reaches DEPTH; all 8 writes appear once each, in order within each channel.
REQ-035 ALU write to r0 with data 0xDEAD -> accepted, o_we stays 0, o_wr_count unchanged.
REQ-036 Load r7 queued while the ALU queue is busy, i_raddr1=7, i_raddr2=0 -> o_busy1=1 until the cycle after r7's o_we pulse; o_busy2 always 0.
REQ-037 Two entries queued, then i_rst pulsed for one cycle -> no o_we afterwards, o_wr_count=0, both readies 1.
REQ-038 Issue 65537 writes -> o_wr_count wraps to 0 after the 65536th write and reads 1 after the last.

Source files
------------

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default widths and queue depth
//   CNT_W                               : width of the issued-write counter
//   src_e                               : writeback source / round-robin id
package reg_wb_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Per-source writeback queue (power-of-two DEPTH).
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_push, i_push_addr/data      : enqueue (ignored when full)
//   i_pop                         : dequeue head (ignored when empty)
//   o_full, o_empty               : occupancy flags
//   o_head_addr, o_head_data      : oldest entry
//   o_vld, o_addr                 : per-slot valid and address for hazard checks
module wb_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_push_addr,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [ADDR_W-1:0]        o_head_addr,
  output logic [DATA_W-1:0]        o_head_data,
  output logic [DEPTH-1:0]         o_vld,
  output logic [DEPTH*ADDR_W-1:0]  o_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic              push_ok, pop_ok;

  assign o_full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign o_empty     = (cnt_q == '0);
  assign push_ok     = i_push & ~o_full;
  assign pop_ok      = i_pop & ~o_empty;
  assign o_head_addr = addr_q[rd_ptr_q];
  assign o_head_data = data_q[rd_ptr_q];
  assign o_vld       = vld_q;

  // Flatten slot addresses for the hazard comparators.
  always_comb begin
    o_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      o_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  // Pointers, occupancy and slot valids.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      // A slot is never pushed and popped together: that needs empty and full at once.
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (push_ok) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset; slot valids qualify it.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= i_push_addr;
      data_q[wr_ptr_q] <= i_push_data;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: two queued writeback channels (ALU,
// load) arbitrated round-robin onto a single registered write port.
//   i_clk, i_rst                          : clock, synchronous active-high reset
//   i_a_valid/addr/data, o_a_ready        : ALU writeback channel
//   i_l_valid/addr/data, o_l_ready        : load-unit writeback channel
//   i_raddr1/2, o_busy1/2                 : decode hazard query (combinational)
//   o_we, o_waddr, o_wdata                : register-file write port
//   o_wr_count                            : issued-write counter (wraps)
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_l_valid,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_data,
  output logic              o_l_ready,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [CNT_W-1:0]  o_wr_count
);

  logic                    a_full, a_empty, l_full, l_empty;
  logic [ADDR_W-1:0]       a_head_addr, l_head_addr;
  logic [DATA_W-1:0]       a_head_data, l_head_data;
  logic [DEPTH-1:0]        a_vld, l_vld;
  logic [DEPTH*ADDR_W-1:0] a_slot_addr, l_slot_addr;
  logic                    a_push, l_push, gnt_a, gnt_l;

  src_e              rr_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  assign o_a_ready = ~a_full;
  assign o_l_ready = ~l_full;

  // Writes to r0 complete the handshake but are dropped here.
  assign a_push = i_a_valid & o_a_ready & (i_a_addr != '0);
  assign l_push = i_l_valid & o_l_ready & (i_l_addr != '0);

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_a_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (a_push),
    .i_push_addr(i_a_addr),
    .i_push_data(i_a_data),
    .i_pop      (gnt_a),
    .o_full     (a_full),
    .o_empty    (a_empty),
    .o_head_addr(a_head_addr),
    .o_head_data(a_head_data),
    .o_vld      (a_vld),
    .o_addr     (a_slot_addr)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_l_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (l_push),
    .i_push_addr(i_l_addr),
    .i_push_data(i_l_data),
    .i_pop      (gnt_l),
    .o_full     (l_full),
    .o_empty    (l_empty),
    .o_head_addr(l_head_addr),
    .o_head_data(l_head_data),
    .o_vld      (l_vld),
    .o_addr     (l_slot_addr)
  );

  // rr_q names the channel favoured at the next contest.
  assign gnt_a = ~a_empty & (l_empty | (rr_q == SRC_ALU));
  assign gnt_l = ~l_empty & ~gnt_a;

  // Arbiter pointer, write port and issue counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q    <= SRC_ALU;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q <= gnt_a | gnt_l;
      if (gnt_a) begin
        rr_q    <= SRC_LD;
        waddr_q <= a_head_addr;
        wdata_q <= a_head_data;
      end else if (gnt_l) begin
        rr_q    <= SRC_ALU;
        waddr_q <= l_head_addr;
        wdata_q <= l_head_data;
      end
      if (gnt_a | gnt_l) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_wr_count = cnt_q;

  // Hazard: read address matches any queued entry or the write in flight.
  always_comb begin
    o_busy1 = 1'b0;
    o_busy2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a_vld[i] && (a_slot_addr[i*ADDR_W +: ADDR_W] == i_raddr1)) o_busy1 = 1'b1;
      if (l_vld[i] && (l_slot_addr[i*ADDR_W +: ADDR_W] == i_raddr1)) o_busy1 = 1'b1;
      if (a_vld[i] && (a_slot_addr[i*ADDR_W +: ADDR_W] == i_raddr2)) o_busy2 = 1'b1;
      if (l_vld[i] && (l_slot_addr[i*ADDR_W +: ADDR_W] == i_raddr2)) o_busy2 = 1'b1;
    end
    if (we_q && (waddr_q == i_raddr1)) o_busy1 = 1'b1;
    if (we_q && (waddr_q == i_raddr2)) o_busy2 = 1'b1;
    if (i_raddr1 == '0) o_busy1 = 1'b0;
    if (i_raddr2 == '0) o_busy2 = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl.
module tb_reg_wb_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_a_valid, i_l_valid;
  logic [4:0]  i_a_addr, i_l_addr, i_raddr1, i_raddr2;
  logic [31:0] i_a_data, i_l_data;
  logic        o_a_ready, o_l_ready, o_busy1, o_busy2, o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [15:0] o_wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  reg_wb_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_a_valid (i_a_valid),
    .i_a_addr  (i_a_addr),
    .i_a_data  (i_a_data),
    .o_a_ready (o_a_ready),
    .i_l_valid (i_l_valid),
    .i_l_addr  (i_l_addr),
    .i_l_data  (i_l_data),
    .o_l_ready (o_l_ready),
    .i_raddr1  (i_raddr1),
    .i_raddr2  (i_raddr2),
    .o_busy1   (o_busy1),
    .o_busy2   (o_busy2),
    .o_we      (o_we),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_wr_count(o_wr_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample/drive 1ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_a_valid = 1'b0; i_a_addr = '0; i_a_data = '0;
    i_l_valid = 1'b0; i_l_addr = '0; i_l_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  logic [4:0]  exp_addr [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
  logic [31:0] exp_data [8] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3};
  logic [4:0]  got_addr [16];
  logic [31:0] got_data [16];

  initial begin
    int ia, il, nw, acc, nwr, cyc;
    logic fa, fl, saw_l_full, saw_a_full;
    logic b1_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic we_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    i_raddr1 = '0; i_raddr2 = '0;
    do_reset();

    // Reset state
    chk("rst_we",    64'(o_we), 64'd0);
    chk("rst_waddr", 64'(o_waddr), 64'd0);
    chk("rst_wdata", 64'(o_wdata), 64'd0);
    chk("rst_cnt",   64'(o_wr_count), 64'd0);
    chk("rst_ardy",  64'(o_a_ready), 64'd1);
    chk("rst_lrdy",  64'(o_l_ready), 64'd1);
    chk("rst_busy1", 64'(o_busy1), 64'd0);
    chk("rst_busy2", 64'(o_busy2), 64'd0);

    // Single ALU write r5 = 0xAA: write port one edge after acceptance
    i_a_valid = 1'b1; i_a_addr = 5'd5; i_a_data = 32'hAA; i_raddr1 = 5'd5;
    step();
    idle_inputs();
    chk("single_busy_q", 64'(o_busy1), 64'd1);
    chk("single_we0",    64'(o_we), 64'd0);
    step();
    chk("single_we",    64'(o_we), 64'd1);
    chk("single_waddr", 64'(o_waddr), 64'd5);
    chk("single_wdata", 64'(o_wdata), 64'hAA);
    chk("single_cnt",   64'(o_wr_count), 64'd1);
    chk("single_busy_w", 64'(o_busy1), 64'd1);
    step();
    chk("single_we_off", 64'(o_we), 64'd0);
    chk("single_hold_a", 64'(o_waddr), 64'd5);
    chk("single_hold_d", 64'(o_wdata), 64'hAA);
    chk("single_busy_clr", 64'(o_busy1), 64'd0);
    i_raddr1 = '0;

    // r0 write is accepted and discarded
    chk("r0_ready", 64'(o_a_ready), 64'd1);
    i_a_valid = 1'b1; i_a_addr = 5'd0; i_a_data = 32'hDEAD;
    step();
    idle_inputs();
    chk("r0_we1", 64'(o_we), 64'd0);
    step();
    chk("r0_we2", 64'(o_we), 64'd0);
    step();
    chk("r0_we3", 64'(o_we), 64'd0);
    chk("r0_cnt", 64'(o_wr_count), 64'd1);

    // Both channels saturated: alternating A,L grants after reset
    do_reset();
    ia = 0; il = 0; nw = 0; saw_l_full = 1'b0; saw_a_full = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (o_we && nw < 16) begin
        got_addr[nw] = o_waddr; got_data[nw] = o_wdata; nw++;
      end
      if (!o_l_ready) saw_l_full = 1'b1;
      if (!o_a_ready) saw_a_full = 1'b1;
      i_a_valid = (ia < 4); i_a_addr = 5'(ia + 1);  i_a_data = 32'hA0 + 32'(ia);
      i_l_valid = (il < 4); i_l_addr = 5'(il + 11); i_l_data = 32'hB0 + 32'(il);
      fa = i_a_valid && o_a_ready;
      fl = i_l_valid && o_l_ready;
      step();
      if (fa) ia++;
      if (fl) il++;
    end
    idle_inputs();
    chk("rr_nwrites", 64'(nw), 64'd8);
    chk("rr_l_full",  64'(saw_l_full), 64'd1);
    chk("rr_a_full",  64'(saw_a_full), 64'd1);
    chk("rr_cnt",     64'(o_wr_count), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < nw) begin
        chk($sformatf("rr_addr%0d", k), 64'(got_addr[k]), 64'(exp_addr[k]));
        chk($sformatf("rr_data%0d", k), 64'(got_data[k]), 64'(exp_data[k]));
      end
    end

    // Hazard: load r7 waits behind contest, busy1 held through its write
    do_reset();
    i_raddr1 = 5'd7; i_raddr2 = 5'd0;
    i_a_valid = 1'b1; i_a_addr = 5'd2; i_a_data = 32'h22;
    i_l_valid = 1'b1; i_l_addr = 5'd7; i_l_data = 32'h77;
    step();
    i_l_valid = 1'b0;
    i_a_addr = 5'd3; i_a_data = 32'h33;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("haz_busy1_%0d", c), 64'(o_busy1), 64'(b1_exp[c]));
      chk($sformatf("haz_busy2_%0d", c), 64'(o_busy2), 64'd0);
      chk($sformatf("haz_we_%0d", c), 64'(o_we), 64'(we_exp[c]));
      if (c == 2) chk("haz_waddr7", 64'(o_waddr), 64'd7);
      step();
      i_a_valid = 1'b0;
    end
    i_raddr1 = '0;

    // Reset mid-operation drops queued entries and ignores transfers
    do_reset();
    i_a_valid = 1'b1; i_a_addr = 5'd1; i_a_data = 32'h1;
    i_l_valid = 1'b1; i_l_addr = 5'd11; i_l_data = 32'h11;
    step();
    i_rst = 1'b1;
    i_a_addr = 5'd9; i_a_data = 32'h9;
    step();
    i_rst = 1'b0;
    idle_inputs();
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_we) nw++;
      step();
    end
    chk("mrst_nwe",  64'(nw), 64'd0);
    chk("mrst_cnt",  64'(o_wr_count), 64'd0);
    chk("mrst_ardy", 64'(o_a_ready), 64'd1);
    chk("mrst_lrdy", 64'(o_l_ready), 64'd1);

    // Counter wrap over 65537 writes
    do_reset();
    acc = 0; nwr = 0; cyc = 0;
    while (nwr < 65537 && cyc < 70000) begin
      i_a_valid = (acc < 65537); i_a_addr = 5'd1; i_a_data = 32'(acc);
      fa = i_a_valid && o_a_ready;
      step();
      cyc++;
      if (fa) acc++;
      if (o_we) begin
        nwr++;
        if (nwr == 65535) chk("wrap_65535", 64'(o_wr_count), 64'hFFFF);
        if (nwr == 65536) chk("wrap_zero",  64'(o_wr_count), 64'd0);
      end
    end
    idle_inputs();
    chk("wrap_nwr",  64'(nwr), 64'd65537);
    chk("wrap_last", 64'(o_wr_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
